fifo8x9_ctrl: RTL

FIFO8X9_CTRL -- requirements
Module: fifo8x9_ctrl

---
 rtl/fifo8x9_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo8x9_ctrl.sv
// rtl/fifo8x9_ctrl.sv - two-producer/one-consumer control for a FIFO8x9 storage block
module fifo8x9_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_req,
    output logic [1:0]       wr_gnt,
    input  logic             rd_req,
    output logic             rd_valid,
    input  logic             flush,
    output logic             WrPtrClr,
    output logic             RdPtrClr,
    output logic             wren,
    output logic             WrInc,
    output logic             rden,
    output logic             RdInc,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             wr_drop
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_gnt;
    logic             last_gnt_nxt;
    logic             gnt_idx;
    logic [CNT_W-1:0] count_nxt;

    // Flags come from the registered occupancy so they never depend on this cycle's requests.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Pointer increments to the storage block track the enables one-for-one.
    assign WrInc = wren;
    assign RdInc = rden;

    // State register; reset parks the block in CLEAR so both pointers are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy, arbitration history and the one-cycle-late read valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            last_gnt <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            count    <= count_nxt;
            last_gnt <= last_gnt_nxt;
            rd_valid <= rden;
        end
    end

    // Next state, strobes, round-robin grant and occupancy update.
    always_comb begin
        state_nxt    = state;
        wr_gnt       = 2'b00;
        wren         = 1'b0;
        rden         = 1'b0;
        wr_drop      = 1'b0;
        WrPtrClr     = 1'b1;
        RdPtrClr     = 1'b1;
        count_nxt    = '0;
        last_gnt_nxt = last_gnt;
        gnt_idx      = 1'b0;
        case (state)
            ST_CLEAR: state_nxt = ST_RUN;
            ST_FLUSH: state_nxt = ST_RUN;
            ST_RUN: begin
                WrPtrClr  = 1'b0;
                RdPtrClr  = 1'b0;
                count_nxt = count;
                if (flush) begin
                    // flush wins over everything else this cycle
                    state_nxt = ST_FLUSH;
                end else begin
                    if (wr_req != 2'b00) begin
                        if (full) begin
                            wr_drop = 1'b1;
                        end else begin
                            // contention alternates; a lone requester wins outright
                            gnt_idx      = (wr_req == 2'b11) ? ~last_gnt : wr_req[1];
                            wr_gnt       = gnt_idx ? 2'b10 : 2'b01;
                            wren         = 1'b1;
                            last_gnt_nxt = gnt_idx;
                        end
                    end
                    if (rd_req && !empty) begin
                        rden = 1'b1;
                    end
                    case ({wren, rden})
                        2'b10:   count_nxt = count + CNT_W'(1);
                        2'b01:   count_nxt = count - CNT_W'(1);
                        default: count_nxt = count;
                    endcase
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

endmodule
